uart_matrix_formatter: RTL

Transmit-side counterpart to the matrix text parser. Takes a matrix (dimensions plus 25×8-bit row-major flat array) and streams it as ASCII text, one byte at a time, to the UART transmitter. Uses the same text format the parser accepts, so a printed matrix can be echoed back and re-parsed. Sits between the matrix storage/compute logic and the UART TX block.

---
 rtl/uart_matrix_formatter_pkg.sv | 30 +++
 rtl/uart_matrix_formatter_bin2bcd8.sv | 30 +++
 rtl/uart_matrix_formatter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_matrix_formatter_pkg.sv
// Shared constants and state encoding for the matrix text parser, formatter and UART blocks.
package uart_matrix_formatter_pkg;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  localparam int MAT_MAX_DIM = 5;
  localparam int ELEM_W      = 8;
  localparam int FLAT_W      = MAT_MAX_DIM * MAT_MAX_DIM * ELEM_W;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_M,
    ST_HDR_SP,
    ST_HDR_N,
    ST_DIGIT,
    ST_SEP,
    ST_EOL_CR,
    ST_EOL_LF,
    ST_WAIT_TX,
    ST_FINISH
  } fmt_state_t;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (d <= 3'(MAT_MAX_DIM));
  endfunction

endpackage

// File: rtl/uart_matrix_formatter_bin2bcd8.sv
// Combinational 8-bit binary to 3-digit BCD via compare-subtract.
module bin2bcd8 (
  input  logic [7:0] bin,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [7:0] rem;

  always_comb begin
    rem      = bin;
    hundreds = '0;
    tens     = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (rem >= 8'd100) begin
        rem      = rem - 8'd100;
        hundreds = hundreds + 4'd1;
      end
    end
    for (int unsigned i = 0; i < 9; i++) begin
      if (rem >= 8'd10) begin
        rem  = rem - 8'd10;
        tens = tens + 4'd1;
      end
    end
    ones = rem[3:0];
  end

endmodule

// File: rtl/uart_matrix_formatter.sv
// Streams a matrix (optional "m n" header, then rows) as ASCII text to a UART transmitter.
module uart_matrix_formatter
  import uart_matrix_formatter_pkg::*;
#(
  parameter int CLK_FREQ_HZ       = 100_000_000,
  parameter int TX_TIMEOUT_CYCLES = CLK_FREQ_HZ / 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              print_header,
  input  logic [2:0]        mat_m,
  input  logic [2:0]        mat_n,
  input  logic [FLAT_W-1:0] matrix_flat,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] WD_LAST = 32'(TX_TIMEOUT_CYCLES - 1);

  fmt_state_t        state, phase, nxt_phase;
  logic [2:0]        m_r, n_r, row, col;
  logic [2:0]        src_m, src_n, nxt_row, nxt_col;
  logic [1:0]        dig, nxt_dig;
  logic              in_hdr, nxt_hdr, nxt_last, pick_first, idle, emit;
  logic [FLAT_W-1:0] flat_r, src_flat;
  logic [4:0]        elem_k;
  logic [ELEM_W-1:0] elem;
  logic [3:0]        bcd_h, bcd_t, bcd_o;
  logic [7:0]        nxt_byte;
  logic [31:0]       wd;

  // The byte-emitting states are evaluated as a lookahead on the transition out of
  // IDLE/WAIT_TX, so tx_start lands one cycle after start or tx_done; `phase` records
  // which of them was last emitted while the FSM itself sits in WAIT_TX.
  always_comb begin
    idle       = (state == ST_IDLE);
    src_m      = idle ? mat_m : m_r;
    src_n      = idle ? mat_n : n_r;
    src_flat   = idle ? matrix_flat : flat_r;
    nxt_phase  = phase;
    nxt_row    = row;
    nxt_col    = col;
    nxt_hdr    = in_hdr;
    nxt_last   = 1'b0;
    pick_first = 1'b0;
    if (idle) begin
      nxt_row = '0;
      nxt_col = '0;
      nxt_hdr = print_header;
      if (print_header) begin
        nxt_phase = ST_HDR_M;
      end else begin
        nxt_phase  = ST_DIGIT;
        pick_first = 1'b1;
      end
    end else begin
      case (phase)
        ST_HDR_M:  nxt_phase = ST_HDR_SP;
        ST_HDR_SP: nxt_phase = ST_HDR_N;
        ST_HDR_N:  nxt_phase = ST_EOL_CR;
        ST_DIGIT: begin
          if (dig != 2'd2)            nxt_phase = ST_DIGIT;
          else if (col < src_n - 3'd1) nxt_phase = ST_SEP;
          else                         nxt_phase = ST_EOL_CR;
        end
        ST_SEP: begin
          nxt_phase  = ST_DIGIT;
          nxt_col    = col + 3'd1;
          pick_first = 1'b1;
        end
        ST_EOL_CR: nxt_phase = ST_EOL_LF;
        ST_EOL_LF: begin
          if (in_hdr) begin
            nxt_hdr    = 1'b0;
            nxt_phase  = ST_DIGIT;
            nxt_row    = '0;
            nxt_col    = '0;
            pick_first = 1'b1;
          end else if (row == src_m - 3'd1) begin
            nxt_last = 1'b1;
          end else begin
            nxt_phase  = ST_DIGIT;
            nxt_row    = row + 3'd1;
            nxt_col    = '0;
            pick_first = 1'b1;
          end
        end
        default: ;
      endcase
    end
    elem_k = 5'(nxt_row) * 5'(src_n) + 5'(nxt_col);
    elem   = (elem_k < 5'(MAT_MAX_DIM * MAT_MAX_DIM)) ? src_flat[{elem_k, 3'b000} +: ELEM_W] : '0;
  end

  bin2bcd8 u_bcd (
    .bin      (elem),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .ones     (bcd_o)
  );

  always_comb begin
    if (pick_first)
      nxt_dig = (bcd_h != 4'd0) ? 2'd0 : ((bcd_t != 4'd0) ? 2'd1 : 2'd2);
    else if (nxt_phase == ST_DIGIT)
      nxt_dig = dig + 2'd1;
    else
      nxt_dig = dig;

    nxt_byte = '0;
    case (nxt_phase)
      ST_HDR_M:  nxt_byte = ASCII_ZERO + {5'd0, src_m};
      ST_HDR_N:  nxt_byte = ASCII_ZERO + {5'd0, src_n};
      ST_HDR_SP,
      ST_SEP:    nxt_byte = ASCII_SP;
      ST_EOL_CR: nxt_byte = ASCII_CR;
      ST_EOL_LF: nxt_byte = ASCII_LF;
      ST_DIGIT: begin
        case (nxt_dig)
          2'd0:    nxt_byte = ASCII_ZERO + {4'd0, bcd_h};
          2'd1:    nxt_byte = ASCII_ZERO + {4'd0, bcd_t};
          default: nxt_byte = ASCII_ZERO + {4'd0, bcd_o};
        endcase
      end
      default: ;
    endcase

    emit = (idle && start && dim_ok(mat_m) && dim_ok(mat_n)) ||
           (state == ST_WAIT_TX && tx_done && !nxt_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      phase    <= ST_IDLE;
      m_r      <= '0;
      n_r      <= '0;
      flat_r   <= '0;
      row      <= '0;
      col      <= '0;
      dig      <= '0;
      in_hdr   <= 1'b0;
      wd       <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      if (emit) begin
        phase    <= nxt_phase;
        row      <= nxt_row;
        col      <= nxt_col;
        dig      <= nxt_dig;
        in_hdr   <= nxt_hdr;
        tx_data  <= nxt_byte;
        tx_start <= 1'b1;
        wd       <= '0;
        busy     <= 1'b1;
        state    <= ST_WAIT_TX;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (dim_ok(mat_m) && dim_ok(mat_n)) begin
              m_r    <= mat_m;
              n_r    <= mat_n;
              flat_r <= matrix_flat;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ST_WAIT_TX: begin
          if (tx_done) begin
            if (nxt_last) state <= ST_FINISH;
          end else if (wd == WD_LAST) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            wd <= wd + 32'd1;
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
